novacore_pio_ext: RTL and testbench
===================================

NOVACORE_PIO_EXT -- requirements
Module: novacore_pio_ext

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 8, port width in bits (1..32).
- RESET_VALUE, 0, out_port value after reset.
- EDGE_MODE, 0, edge-capture mode: 0 rising, 1 falling, 2 any.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- reset_n, in, 1, reset: asynchronous, active-low.
- address, in, 3, register select.
- chipselect, in, 1, slave select.
- write_n, in, 1, active-low write strobe.
- writedata, in, 32, write data.
- readdata, out, 32, read data.
- in_port, in, WIDTH, asynchronous external inputs.
- out_port, out, WIDTH, registered outputs.
- irq, out, 1, registered level interrupt.

Function
REQ-003 Register map SHALL be:
- 0: DATA (read/write out_port).
- 1: INPUT (read-only, synchronized in_port).
- 2: IRQMASK (read/write).
- 3: EDGECAP (read; write-1-to-clear).
- 4: OUTSET.
- 5: OUTCLR.
- 6-7: reserved, read 0, writes ignored.

REQ-004 Write SHALL occur on the clk edge where chipselect=1 and write_n=0; only writedata[WIDTH-1:0] SHALL be used.

REQ-005 readdata SHALL be combinational from address with zero wait states; bits [31:WIDTH] SHALL read 0.

REQ-006 out_port SHALL equal the DATA register; a DATA write SHALL be visible on out_port after that edge.

REQ-007 in_port SHALL pass through a 2-flop synchronizer; INPUT SHALL reflect an in_port change after the 2nd rising edge.

REQ-008 On the 3rd edge, an EDGECAP bit SHALL set when the synchronized bit shows the selected edge versus its previous sampled value.

REQ-009 EDGECAP bits SHALL remain set until cleared by writing 1 to that bit; writing 0 SHALL have no effect.

REQ-010 If an edge-capture set and a write-1-clear hit the same bit on the same edge, set SHALL win.

REQ-011 irq SHALL register |(EDGECAP & IRQMASK) one cycle after EDGECAP updates; clearing all unmasked bits SHALL drop irq on the following edge.

REQ-012 Writing IRQMASK with a bit already captured SHALL assert irq on the next edge.

Reset
REQ-013 While reset_n=0, the following SHALL hold:
- DATA = RESET_VALUE.
- IRQMASK = 0.
- EDGECAP = 0.
- Synchronizer and previous-sample flops = 0.
- irq = 0.

REQ-014 Reset assertion mid-operation SHALL clear the state in REQ-013 immediately; no edge SHALL be captured on the first edge after release caused by the synchronizer-flush transition.

Configuration
REQ-015 With NOVACORE_PIO_BITSET_EN defined:
- A write to OUTSET SHALL perform DATA |= writedata.
- A write to OUTCLR SHALL perform DATA &= ~writedata.
- Reads of OUTSET and OUTCLR SHALL return 0.

REQ-016 Without NOVACORE_PIO_BITSET_EN, addresses 4 and 5 SHALL behave as reserved.

Structure
REQ-017 Package novacore_pio_pkg SHALL hold:
- Register address constants.
- EDGE_MODE encoding constants.

REQ-018 The synchronizer SHALL be sub-module novacore_sync2, parametrised by WIDTH.

Verification
REQ-019 The bench SHALL cover the following directed scenarios (stimulus -> required response):
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, irq=0, all registers read back reset values.
- Write DATA=8'h3C, read addr 0 -> readdata=32'h0000003C; write addr 1 ignored.
- EDGE_MODE=0, IRQMASK=8'h01, in_port[0] 0->1 -> INPUT bit0=1 after edge 2, EDGECAP=8'h01 after edge 3, irq=1 after edge 4.
- EDGECAP clear (write 8'h01) on the same cycle a new rising edge is captured -> bit remains 1, irq stays 1; clear without a new edge -> irq=0 one cycle later.
- BITSET_EN: DATA=8'hF0, OUTSET 8'h0F, then OUTCLR 8'h81 -> out_port=8'hFF, then 8'h7E; without the macro, DATA unchanged and reads return 0.

Source files
------------

// File: rtl/novacore_pio_pkg.sv
// Shared constants for the NovaCore parallel I/O port: register addresses and
// edge-capture mode encodings.
package novacore_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_INPUT   = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/novacore_sync2.sv
// Two-flop synchronizer bringing asynchronous inputs into the clk domain.
module novacore_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/novacore_pio_ext.sv
// Memory-mapped parallel I/O port with synchronized inputs, edge capture and a
// masked level interrupt. Define NOVACORE_PIO_BITSET_EN to enable OUTSET/OUTCLR.
module novacore_pio_ext
  import novacore_pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter int          EDGE_MODE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] prev_q;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;
  logic [31:0]      rdata;
  logic             unused_wdata;

  novacore_sync2 #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (in_port),
    .q_o     (sync_in)
  );

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  always_comb begin
    case (EDGE_MODE)
      EDGE_FALLING: edge_hit = ~sync_in & prev_q;
      EDGE_ANY:     edge_hit = sync_in ^ prev_q;
      default:      edge_hit = sync_in & ~prev_q;
    endcase
  end

  // A capture and a write-1-to-clear on the same bit resolve in favour of the capture.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    clr    = '0;
    if (wr_en) begin
      case (address)
        ADDR_DATA:    data_d = wdata;
        ADDR_IRQMASK: mask_d = wdata;
        ADDR_EDGECAP: clr    = wdata;
`ifdef NOVACORE_PIO_BITSET_EN
        ADDR_OUTSET:  data_d = data_q | wdata;
        ADDR_OUTCLR:  data_d = data_q & ~wdata;
`else
        ADDR_OUTSET, ADDR_OUTCLR: ;
`endif
        default: ;
      endcase
    end
    edgecap_d = (edgecap_q & ~clr) | edge_hit;
    irq_d     = |(edgecap_q & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= RESET_VALUE[WIDTH-1:0];
      mask_q    <= '0;
      edgecap_q <= '0;
      prev_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      data_q    <= data_d;
      mask_q    <= mask_d;
      edgecap_q <= edgecap_d;
      prev_q    <= sync_in;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (address)
      ADDR_DATA:    rdata[WIDTH-1:0] = data_q;
      ADDR_INPUT:   rdata[WIDTH-1:0] = sync_in;
      ADDR_IRQMASK: rdata[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: rdata[WIDTH-1:0] = edgecap_q;
      default: ;
    endcase
  end

  assign readdata = rdata;
  assign out_port = data_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_novacore_pio_ext.sv
// Self-checking bench for novacore_pio_ext: directed scenarios plus randomized
// traffic compared every cycle against a delay-line behavioural model.
module tb_novacore_pio_ext;

  localparam int W  = 8;
  localparam int EM = 0;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic [2:0]    address    = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = 32'd0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port    = '0;
  logic [W-1:0]  out_port;
  logic          irq;

  int testsRun    = 0;
  int testsFailed = 0;
  logic cmpEn = 1'b0;

  always #5 clk = ~clk;

  novacore_pio_ext #(
    .WIDTH       (W),
    .RESET_VALUE (32'hA5),
    .EDGE_MODE   (EM)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .irq        (irq)
  );

  // Behavioural model: inHist[k] is the in_port value sampled k edges ago
  // (index 0 = most recent edge). The synchronized view lags by two edges,
  // and an edge is judged one edge later against the sample before it.
  logic [W-1:0] mData, mMask, mCap;
  logic         mIrq;
  logic [W-1:0] inHist[$];
  logic [W-1:0] mWd, mClr, mHit;
  logic         mIrqNext;

  function automatic void modelReset();
    mData = 8'hA5;
    mMask = '0;
    mCap  = '0;
    mIrq  = 1'b0;
    inHist.delete();
    for (int i = 0; i < 4; i++) inHist.push_back('0);
  endfunction

  function automatic logic [31:0] modelRead(input logic [2:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      3'd0: r[W-1:0] = mData;
      3'd1: r[W-1:0] = inHist[1];
      3'd2: r[W-1:0] = mMask;
      3'd3: r[W-1:0] = mCap;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // The model advances on every clock edge and resets asynchronously like the DUT.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      modelReset();
    end else begin
      mIrqNext = |(mCap & mMask);
      inHist.push_front(in_port);
      void'(inHist.pop_back());
      case (EM)
        1:       mHit = ~inHist[2] & inHist[3];
        2:       mHit = inHist[2] ^ inHist[3];
        default: mHit = inHist[2] & ~inHist[3];
      endcase
      mWd  = writedata[W-1:0];
      mClr = '0;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: mData = mWd;
          3'd2: mMask = mWd;
          3'd3: mClr  = mWd;
`ifdef NOVACORE_PIO_BITSET_EN
          3'd4: mData = mData | mWd;
          3'd5: mData = mData & ~mWd;
`endif
          default: ;
        endcase
      end
      mCap = (mCap & ~mClr) | mHit;
      mIrq = mIrqNext;
    end
  end

  // Shared comparison helper; every check in the bench funnels through here.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("model out_port", {24'd0, out_port}, {24'd0, mData});
      checkOutput("model irq", {31'd0, irq}, {31'd0, mIrq});
      checkOutput("model readdata", readdata, modelRead(address));
    end
  end

  // Drives the bus inputs; callers advance time separately.
  task automatic applyStimulus(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic doWrite(input logic [2:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, a, d);
    tick();
    applyStimulus(1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic checkRead(input string name, input logic [2:0] a, input logic [31:0] expected);
    address = a;
    #1;
    checkOutput(name, readdata, expected);
  endtask

  logic [W-1:0] expSet, expClr;

  initial begin
    modelReset();
    cmpEn = 1'b1;

    // Reset state with RESET_VALUE = 8'hA5
    repeat (3) tick();
    checkOutput("reset out_port", {24'd0, out_port}, 32'h000000A5);
    checkOutput("reset irq", {31'd0, irq}, 32'd0);
    checkRead("reset DATA", 3'd0, 32'h000000A5);
    checkRead("reset INPUT", 3'd1, 32'd0);
    checkRead("reset IRQMASK", 3'd2, 32'd0);
    checkRead("reset EDGECAP", 3'd3, 32'd0);
    checkRead("reset addr4", 3'd4, 32'd0);
    checkRead("reset addr7", 3'd7, 32'd0);
    reset_n = 1'b1;
    tick();

    // DATA write/readback and an ignored write to the read-only INPUT register
    doWrite(3'd0, 32'hFFFFFF3C);
    checkRead("DATA readback", 3'd0, 32'h0000003C);
    checkOutput("DATA out_port", {24'd0, out_port}, 32'h0000003C);
    doWrite(3'd1, 32'h000000FF);
    checkRead("INPUT write ignored", 3'd1, 32'd0);
    checkOutput("DATA after INPUT write", {24'd0, out_port}, 32'h0000003C);

    // Rising edge on bit 0 through synchronizer, capture and interrupt
    doWrite(3'd2, 32'h01);
    in_port = 8'h01;
    tick();
    checkRead("INPUT after edge 1", 3'd1, 32'd0);
    tick();
    checkRead("INPUT after edge 2", 3'd1, 32'h01);
    checkRead("EDGECAP before edge 3", 3'd3, 32'd0);
    tick();
    checkRead("EDGECAP after edge 3", 3'd3, 32'h01);
    checkOutput("irq after edge 3", {31'd0, irq}, 32'd0);
    tick();
    checkOutput("irq after edge 4", {31'd0, irq}, 32'd1);

    // Clear colliding with a new capture keeps the bit; a plain clear drops irq a cycle later
    in_port = 8'h00;
    repeat (4) tick();
    in_port = 8'h01;
    tick();
    tick();
    doWrite(3'd3, 32'h01);
    checkRead("EDGECAP set beats clear", 3'd3, 32'h01);
    checkOutput("irq held through collision", {31'd0, irq}, 32'd1);
    doWrite(3'd3, 32'h01);
    checkRead("EDGECAP cleared", 3'd3, 32'd0);
    checkOutput("irq one edge after clear", {31'd0, irq}, 32'd1);
    tick();
    checkOutput("irq dropped after clear", {31'd0, irq}, 32'd0);

    // Unmasking an already-captured bit raises irq on the following edge
    doWrite(3'd2, 32'h00);
    in_port = 8'h03;
    repeat (4) tick();
    checkRead("EDGECAP bit1 captured masked", 3'd3, 32'h02);
    checkOutput("irq masked", {31'd0, irq}, 32'd0);
    doWrite(3'd2, 32'h02);
    checkOutput("irq at mask write edge", {31'd0, irq}, 32'd0);
    tick();
    checkOutput("irq after mask write", {31'd0, irq}, 32'd1);

    // OUTSET / OUTCLR behaviour depends on the build option
`ifdef NOVACORE_PIO_BITSET_EN
    expSet = 8'hFF;
    expClr = 8'h7E;
`else
    expSet = 8'hF0;
    expClr = 8'hF0;
`endif
    doWrite(3'd0, 32'hF0);
    doWrite(3'd4, 32'h0F);
    checkOutput("OUTSET out_port", {24'd0, out_port}, {24'd0, expSet});
    checkRead("OUTSET reads 0", 3'd4, 32'd0);
    doWrite(3'd5, 32'h81);
    checkOutput("OUTCLR out_port", {24'd0, out_port}, {24'd0, expClr});
    checkRead("OUTCLR reads 0", 3'd5, 32'd0);

    // Asynchronous reset mid-operation with inputs held high
    reset_n = 1'b0;
    #1;
    checkOutput("async reset out_port", {24'd0, out_port}, 32'h000000A5);
    checkOutput("async reset irq", {31'd0, irq}, 32'd0);
    checkRead("async reset EDGECAP", 3'd3, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    checkRead("no capture on first edge after release", 3'd3, 32'd0);
    repeat (2) tick();
    checkRead("held-high input captured after sync", 3'd3, 32'h03);

    // Randomized traffic checked by the per-cycle model comparison
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                    3'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end else begin
        tick();
      end
    end
    applyStimulus(1'b0, 1'b1, 3'd0, 32'd0);
    tick();
    tick();

    cmpEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
